// File: rtl/ifs_ctrl.sv
// ifs_ctrl: CAN interframe-space sequencer. It steers the shared bit counter through the
// integration, intermission, suspend and idle phases, and it grants transmission start.
`timescale 1ns/1ps
`default_nettype none

module ifs_ctrl #(
  parameter int CNT_W      = 7,
  parameter int INTER_BITS = 3,
  parameter int SUSP_BITS  = 8,
  parameter int IDLE_BITS  = 11
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             Prescale_EN,
  input  logic             sample_pt,
  input  logic             rx_bit,
  input  logic             frame_end,
  input  logic             susp_req,
  input  logic             tx_req,
  input  logic [CNT_W-1:0] counto,
  output logic             cnt_inc,
  output logic             cnt_rst_n,
  output logic             bus_idle,
  output logic             tx_start,
  output logic             sof_detect,
  output logic             overload_req,
  output logic [2:0]       ifs_state
);

  typedef enum logic [2:0] {
    S_INTEG = 3'd0,
    S_BUSY  = 3'd1,
    S_INTER = 3'd2,
    S_SUSP  = 3'd3,
    S_IDLE  = 3'd4
  } state_e;

  // Last bit index of each counted phase; the >= compares tolerate an overrunning counter
  localparam logic [CNT_W-1:0] IDLE_LAST  = CNT_W'(IDLE_BITS - 1);
  localparam logic [CNT_W-1:0] INTER_LAST = CNT_W'(INTER_BITS - 1);
  localparam logic [CNT_W-1:0] SUSP_LAST  = CNT_W'(SUSP_BITS - 1);

  state_e state_q, state_d;
  logic   susp_pend_q, susp_pend_d;
  logic   cnt_inc_q, cnt_inc_d;
  logic   cnt_rst_n_q, cnt_rst_n_d;
  logic   bus_idle_q, bus_idle_d;
  logic   tx_start_q, tx_start_d;
  logic   sof_q, sof_d;
  logic   ovl_q, ovl_d;

  always_comb begin
    state_d     = state_q;
    susp_pend_d = susp_pend_q;
    cnt_inc_d   = 1'b0;
    cnt_rst_n_d = 1'b1;
    tx_start_d  = 1'b0;
    sof_d       = 1'b0;
    ovl_d       = 1'b0;

    unique case (state_q)
      S_INTEG: begin
        if (sample_pt) begin
          if (!rx_bit) begin
            cnt_rst_n_d = 1'b0;
          end else begin
            cnt_inc_d = 1'b1;
            if (counto >= IDLE_LAST) state_d = S_IDLE;
          end
        end
      end

      S_BUSY: begin
        cnt_rst_n_d = 1'b0;
        if (frame_end) begin
          state_d     = S_INTER;
          susp_pend_d = susp_req;
        end
      end

      S_INTER: begin
        if (sample_pt) begin
          if (!rx_bit) begin
            state_d     = S_BUSY;
            cnt_rst_n_d = 1'b0;
            if (counto < INTER_LAST) begin
              ovl_d = 1'b1;
            end else begin
              sof_d      = 1'b1;
              tx_start_d = tx_req && !susp_pend_q;
            end
          end else if (counto >= INTER_LAST) begin
            if (susp_pend_q) begin
              state_d     = S_SUSP;
              cnt_rst_n_d = 1'b0;
            end else if (tx_req) begin
              state_d     = S_BUSY;
              tx_start_d  = 1'b1;
              cnt_rst_n_d = 1'b0;
            end else begin
              state_d   = S_IDLE;
              cnt_inc_d = 1'b1;
            end
          end else begin
            cnt_inc_d = 1'b1;
          end
        end
      end

      S_SUSP: begin
        // A frame started by another node pre-empts our deferred transmission
        if (sample_pt) begin
          if (!rx_bit) begin
            state_d     = S_BUSY;
            sof_d       = 1'b1;
            cnt_rst_n_d = 1'b0;
          end else if (counto >= SUSP_LAST) begin
            susp_pend_d = 1'b0;
            if (tx_req) begin
              state_d     = S_BUSY;
              tx_start_d  = 1'b1;
              cnt_rst_n_d = 1'b0;
            end else begin
              state_d   = S_IDLE;
              cnt_inc_d = 1'b1;
            end
          end else begin
            cnt_inc_d = 1'b1;
          end
        end
      end

      S_IDLE: begin
        if (sample_pt) begin
          if (!rx_bit) begin
            state_d     = S_BUSY;
            sof_d       = 1'b1;
            cnt_rst_n_d = 1'b0;
          end else if (tx_req) begin
            state_d     = S_BUSY;
            tx_start_d  = 1'b1;
            cnt_rst_n_d = 1'b0;
          end
        end
      end

      default: begin
        state_d     = S_INTEG;
        cnt_rst_n_d = 1'b0;
      end
    endcase

    bus_idle_d = (state_d == S_IDLE);
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q     <= S_INTEG;
      susp_pend_q <= 1'b0;
      cnt_inc_q   <= 1'b0;
      cnt_rst_n_q <= 1'b0;
      bus_idle_q  <= 1'b0;
      tx_start_q  <= 1'b0;
      sof_q       <= 1'b0;
      ovl_q       <= 1'b0;
    end else if (Prescale_EN) begin
      state_q     <= state_d;
      susp_pend_q <= susp_pend_d;
      cnt_inc_q   <= cnt_inc_d;
      cnt_rst_n_q <= cnt_rst_n_d;
      bus_idle_q  <= bus_idle_d;
      tx_start_q  <= tx_start_d;
      sof_q       <= sof_d;
      ovl_q       <= ovl_d;
    end
  end

  assign cnt_inc      = cnt_inc_q;
  assign cnt_rst_n    = cnt_rst_n_q;
  assign bus_idle     = bus_idle_q;
  assign tx_start     = tx_start_q;
  assign sof_detect   = sof_q;
  assign overload_req = ovl_q;
  assign ifs_state    = state_q;

endmodule

`default_nettype wire

// File: tb/tb_ifs_ctrl.sv
// tb_ifs_ctrl: directed and random stimulus for ifs_ctrl. Expected events come from a bit-level
// phase model and are checked by a separate monitor through a scoreboard queue.
`timescale 1ns/1ps
`default_nettype none

module tb_ifs_ctrl;
  localparam int CNT_W      = 7;
  localparam int INTER_BITS = 3;
  localparam int SUSP_BITS  = 8;
  localparam int IDLE_BITS  = 11;

  localparam int P_INTEG = 0;
  localparam int P_BUSY  = 1;
  localparam int P_INTER = 2;
  localparam int P_SUSP  = 3;
  localparam int P_IDLE  = 4;

  logic             clock = 1'b0;
  logic             reset = 1'b0;
  logic             Prescale_EN = 1'b0;
  logic             sample_pt = 1'b0;
  logic             rx_bit = 1'b1;
  logic             frame_end = 1'b0;
  logic             susp_req = 1'b0;
  logic             tx_req = 1'b0;
  logic [CNT_W-1:0] counto;
  logic             cnt_inc, cnt_rst_n, bus_idle, tx_start, sof_detect, overload_req;
  logic [2:0]       ifs_state;

  ifs_ctrl #(
    .CNT_W(CNT_W), .INTER_BITS(INTER_BITS), .SUSP_BITS(SUSP_BITS), .IDLE_BITS(IDLE_BITS)
  ) dut (
    .clock(clock), .reset(reset), .Prescale_EN(Prescale_EN), .sample_pt(sample_pt),
    .rx_bit(rx_bit), .frame_end(frame_end), .susp_req(susp_req), .tx_req(tx_req),
    .counto(counto), .cnt_inc(cnt_inc), .cnt_rst_n(cnt_rst_n), .bus_idle(bus_idle),
    .tx_start(tx_start), .sof_detect(sof_detect), .overload_req(overload_req),
    .ifs_state(ifs_state)
  );

  always #5 clock = ~clock;

  // External bit counter, advancing on enabled cycles only
  always @(posedge clock or negedge reset) begin
    if (!reset) counto <= '0;
    else if (Prescale_EN) begin
      if (!cnt_rst_n) counto <= '0;
      else if (cnt_inc) counto <= counto + 1'b1;
    end
  end

  typedef struct {
    int edge_no;
    int st;
    bit tx;
    bit sof;
    bit ovl;
    bit idle;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  int   en_cnt = 0;
  bit   en_edge = 0;

  // Reference model: phase, bits seen in the current phase, pending suspend
  int   m_phase = P_INTEG;
  int   m_pos = 0;
  bit   m_susp = 0;

  initial begin
    forever begin
      @(posedge clock);
      en_edge = Prescale_EN && reset;
      if (en_edge) en_cnt++;
    end
  end

  function automatic void push(input int st, input bit tx, input bit sof, input bit ovl);
    exp_t e;
    e.edge_no = en_cnt + 1;
    e.st      = st;
    e.tx      = tx;
    e.sof     = sof;
    e.ovl     = ovl;
    e.idle    = (st == P_IDLE);
    sb.push_back(e);
    m_phase = st;
  endfunction

  function automatic void model_event(input bit rx, input bit is_sample, input bit is_fe);
    if (is_fe && m_phase == P_BUSY) begin
      m_susp = susp_req;
      m_pos  = 0;
      push(P_INTER, 0, 0, 0);
      return;
    end
    if (!is_sample) return;
    case (m_phase)
      P_INTEG: begin
        if (rx) begin
          m_pos++;
          if (m_pos == IDLE_BITS) push(P_IDLE, 0, 0, 0);
        end else m_pos = 0;
      end
      P_INTER: begin
        if (!rx) begin
          if (m_pos < INTER_BITS - 1) push(P_BUSY, 0, 0, 1);
          else push(P_BUSY, tx_req && !m_susp, 1, 0);
        end else if (m_pos == INTER_BITS - 1) begin
          if (m_susp) begin
            m_pos = 0;
            push(P_SUSP, 0, 0, 0);
          end else if (tx_req) push(P_BUSY, 1, 0, 0);
          else push(P_IDLE, 0, 0, 0);
        end else m_pos++;
      end
      P_SUSP: begin
        if (!rx) push(P_BUSY, 0, 1, 0);
        else if (m_pos == SUSP_BITS - 1) begin
          m_susp = 0;
          if (tx_req) push(P_BUSY, 1, 0, 0);
          else push(P_IDLE, 0, 0, 0);
        end else m_pos++;
      end
      P_IDLE: begin
        if (!rx) push(P_BUSY, 0, 1, 0);
        else if (tx_req) push(P_BUSY, 1, 0, 0);
      end
      default: ;
    endcase
  endfunction

  // Monitor: pops an expected event whenever the DUT shows a pulse or a state change
  initial begin
    int         prev_st;
    logic [8:0] snap;
    logic [8:0] now_v;
    logic [CNT_W-1:0] snap_cnt;
    exp_t       e;
    bit         ev;
    prev_st  = 0;
    snap     = '0;
    snap_cnt = '0;
    forever begin
      @(negedge clock);
      now_v = {ifs_state, cnt_inc, cnt_rst_n, bus_idle, tx_start, sof_detect, overload_req};
      if (!reset) begin
        prev_st = 0;
      end else if (!en_edge) begin
        checks++;
        if (now_v !== snap || counto !== snap_cnt) begin
          errors++;
          $display("FAIL hold: outputs %b cnt %0d, required %b cnt %0d", now_v, counto, snap,
                   snap_cnt);
        end
      end else begin
        checks++;
        if (cnt_inc && !cnt_rst_n) begin
          errors++;
          $display("FAIL inc_vs_rst: cnt_inc=1 with cnt_rst_n=0 at edge %0d, required exclusive",
                   en_cnt);
        end
        while (sb.size() > 0 && sb[0].edge_no < en_cnt) begin
          checks++;
          errors++;
          $display("FAIL missing_event: expected at edge %0d state %0d, got nothing (now %0d)",
                   sb[0].edge_no, sb[0].st, en_cnt);
          void'(sb.pop_front());
        end
        ev = tx_start || sof_detect || overload_req || (int'(ifs_state) != prev_st);
        if (ev) begin
          checks++;
          if (sb.size() == 0) begin
            errors++;
            $display("FAIL unexpected_event: edge %0d state %0d tx %b sof %b ovl %b, required none",
                     en_cnt, ifs_state, tx_start, sof_detect, overload_req);
          end else begin
            e = sb.pop_front();
            if (e.edge_no != en_cnt || e.st != int'(ifs_state) || e.tx != tx_start ||
                e.sof != sof_detect || e.ovl != overload_req || e.idle != bus_idle) begin
              errors++;
              $display("FAIL event: got edge %0d st %0d tx %b sof %b ovl %b idle %b, required edge %0d st %0d tx %b sof %b ovl %b idle %b",
                       en_cnt, ifs_state, tx_start, sof_detect, overload_req, bus_idle,
                       e.edge_no, e.st, e.tx, e.sof, e.ovl, e.idle);
            end
          end
        end
        prev_st = int'(ifs_state);
      end
      snap     = now_v;
      snap_cnt = counto;
    end
  end

  task automatic idle_cycles(input int n_en);
    int k;
    k = 0;
    while (k < n_en) begin
      @(negedge clock);
      sample_pt   = 1'b0;
      frame_end   = 1'b0;
      Prescale_EN = ($urandom_range(0, 3) != 0);
      if (Prescale_EN) k++;
    end
  endtask

  task automatic bit_sample(input bit rx, input bit with_fe);
    @(negedge clock);
    Prescale_EN = 1'b1;
    sample_pt   = 1'b1;
    rx_bit      = rx;
    frame_end   = with_fe;
    model_event(rx, 1'b1, with_fe);
    idle_cycles(3);
  endtask

  task automatic frame_done(input bit susp);
    @(negedge clock);
    Prescale_EN = 1'b1;
    frame_end   = 1'b1;
    susp_req    = susp;
    model_event(1'b1, 1'b0, 1'b1);
    idle_cycles(3);
  endtask

  task automatic recessive(input int n);
    for (int i = 0; i < n; i++) bit_sample(1'b1, 1'b0);
  endtask

  task automatic do_reset();
    idle_cycles(2);
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL pending_before_reset: %0d events outstanding, required 0", sb.size());
    end
    @(negedge clock);
    #2;
    reset       = 1'b0;
    Prescale_EN = 1'b0;
    sample_pt   = 1'b0;
    frame_end   = 1'b0;
    #1;
    checks++;
    if ({ifs_state, cnt_inc, cnt_rst_n, bus_idle, tx_start, sof_detect, overload_req} !== 9'b0) begin
      errors++;
      $display("FAIL reset_values: state %0d inc %b rst_n %b idle %b tx %b sof %b ovl %b, required all 0",
               ifs_state, cnt_inc, cnt_rst_n, bus_idle, tx_start, sof_detect, overload_req);
    end
    sb.delete();
    m_phase = P_INTEG;
    m_pos   = 0;
    m_susp  = 0;
    @(negedge clock);
    #2;
    reset = 1'b1;
    idle_cycles(2);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int kind;
    do_reset();

    // Integration, restarted by a dominant sixth bit
    recessive(5);
    bit_sample(1'b0, 1'b0);
    recessive(IDLE_BITS);

    // Idle -> transmit, intermission back to idle
    tx_req = 1'b1;
    bit_sample(1'b1, 1'b0);
    tx_req = 1'b0;
    frame_done(1'b0);
    recessive(INTER_BITS);

    // Overload at intermission index 1
    bit_sample(1'b0, 1'b0);
    frame_done(1'b0);
    recessive(1);
    bit_sample(1'b0, 1'b0);

    // SOF at last intermission bit with a pending transmission
    tx_req = 1'b1;
    frame_done(1'b0);
    recessive(2);
    bit_sample(1'b0, 1'b0);

    // Suspend: transmission only after 3+8 recessive bits, then a pre-empted suspend
    frame_done(1'b1);
    recessive(INTER_BITS + SUSP_BITS);
    frame_done(1'b1);
    recessive(INTER_BITS + 3);
    bit_sample(1'b0, 1'b0);

    // Disabled enable with sample_pt held during intermission
    tx_req = 1'b0;
    frame_done(1'b0);
    recessive(1);
    @(negedge clock);
    Prescale_EN = 1'b0;
    sample_pt   = 1'b1;
    rx_bit      = 1'b0;
    repeat (4) @(negedge clock);
    idle_cycles(3);
    recessive(2);

    // frame_end ignored outside BUSY; frame_end wins over a same-cycle sample
    frame_done(1'b0);
    bit_sample(1'b0, 1'b0);
    bit_sample(1'b0, 1'b1);
    recessive(1);

    // Asynchronous reset in the middle of a suspend phase
    bit_sample(1'b0, 1'b0);
    frame_done(1'b1);
    recessive(INTER_BITS + 2);
    do_reset();
    recessive(IDLE_BITS);

    for (int n = 0; n < 400; n++) begin
      if ($urandom_range(0, 7) == 0) tx_req = ~tx_req;
      kind = $urandom_range(0, 9);
      if (kind < 3) frame_done($urandom_range(0, 2) == 0);
      else if (kind == 3) bit_sample($urandom_range(0, 1) == 1, 1'b1);
      else bit_sample($urandom_range(0, 5) != 0, 1'b0);
    end

    idle_cycles(4);
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL pending_at_end: %0d events outstanding, required 0", sb.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
